// File: rtl/voice_mix_n.sv
// rtl/voice_mix_n.sv - time-multiplexed N-oscillator voice mixer; optional macro VOICE_MIX_CLIP_CNT_EN adds clip/clip_count
`timescale 1ns/1ps
module voice_mix_n #(
  parameter int              NUM_OSC = 4,
  parameter int              WIDTH   = 16,
  parameter logic [WIDTH-1:0] SLEW   = 16'h0088
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     sample_tick,
  input  logic [NUM_OSC*WIDTH-1:0] osc_in,
  input  logic [NUM_OSC*WIDTH-1:0] amp_in,
  input  logic [WIDTH-1:0]         env_in,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic                     busy
`ifdef VOICE_MIX_CLIP_CNT_EN
  ,
  output logic                     clip,
  output logic [15:0]              clip_count
`endif
);

  localparam int KW   = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1;
  localparam int ACCW = WIDTH + $clog2(NUM_OSC) + 1;
  localparam int PW   = 2 * WIDTH + 1;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-(2 ** (WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, ACC, SCALE, DONE} state_t;

  state_t state, state_nx;
  logic [KW-1:0]              k;
  // Snapshot is shifted down one channel per ACC step, so the live channel is always the low slice.
  logic [NUM_OSC*WIDTH-1:0]   osc_q;
  logic [NUM_OSC*WIDTH-1:0]   amp_q;
  logic [WIDTH-1:0]           env_q;
  logic [WIDTH-1:0]           amp_s [NUM_OSC];
  logic signed [ACCW-1:0]     acc;
  logic signed [WIDTH-1:0]    g_q;

  logic [WIDTH-1:0]           amp_cur;
  logic [WIDTH-1:0]           amp_new;
  logic [WIDTH:0]             tgt_x, cur_x, slew_x;
  logic signed [PW-1:0]       prod;
  logic signed [ACCW-1:0]     term;
  logic                       sat_hi, sat_lo;
  logic signed [WIDTH-1:0]    sat;
  logic signed [PW-1:0]       gprod;
  logic signed [WIDTH-1:0]    g;
`ifdef VOICE_MIX_CLIP_CNT_EN
  logic                       sat_q;
`endif

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: one channel per ACC cycle, then one cycle each for SCALE and DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (sample_tick) state_nx = ACC;
      ACC:     if (k == KW'(NUM_OSC - 1)) state_nx = SCALE;
      SCALE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Slew limiter, channel scaling, accumulator saturation and envelope gain.
  always_comb begin
    amp_cur = amp_s[k];
    tgt_x   = {1'b0, amp_q[WIDTH-1:0]};
    cur_x   = {1'b0, amp_cur};
    slew_x  = {1'b0, SLEW};
    if (SLEW == '0)                     amp_new = amp_q[WIDTH-1:0];
    else if (tgt_x > cur_x + slew_x)    amp_new = amp_cur + SLEW;
    else if (tgt_x + slew_x < cur_x)    amp_new = amp_cur - SLEW;
    else                                amp_new = amp_q[WIDTH-1:0];
    prod   = PW'($signed(osc_q[WIDTH-1:0])) * PW'($signed({1'b0, amp_new}));
    term   = ACCW'(prod >>> WIDTH);
    sat_hi = (acc > SAT_MAX);
    sat_lo = (acc < SAT_MIN);
    if (sat_hi)      sat = {1'b0, {(WIDTH-1){1'b1}}};
    else if (sat_lo) sat = {1'b1, {(WIDTH-1){1'b0}}};
    else             sat = WIDTH'(acc);
    gprod  = PW'(sat) * PW'($signed({1'b0, env_q}));
    g      = WIDTH'(gprod >>> WIDTH);
  end

  // Datapath registers: snapshot, per-channel smoothed amplitude, accumulator and output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      k         <= '0;
      osc_q     <= '0;
      amp_q     <= '0;
      env_q     <= '0;
      acc       <= '0;
      g_q       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NUM_OSC; i++) amp_s[i] <= '0;
`ifdef VOICE_MIX_CLIP_CNT_EN
      sat_q      <= 1'b0;
      clip       <= 1'b0;
      clip_count <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            osc_q <= osc_in;
            amp_q <= amp_in;
            env_q <= env_in;
            acc   <= '0;
            k     <= '0;
          end
        end
        ACC: begin
          amp_s[k] <= amp_new;
          acc      <= acc + term;
          k        <= k + 1'b1;
          osc_q    <= osc_q >> WIDTH;
          amp_q    <= amp_q >> WIDTH;
        end
        SCALE: begin
          g_q <= g;
`ifdef VOICE_MIX_CLIP_CNT_EN
          sat_q <= sat_hi | sat_lo;
`endif
        end
        DONE: begin
          out       <= g_q;
          out_valid <= 1'b1;
`ifdef VOICE_MIX_CLIP_CNT_EN
          clip <= sat_q;
          if (sat_q && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/voice_mix_n.md
Name: voice_mix_n

Overview:
Parametrised N-oscillator voice mixer, the next generation of the per-voice output stage. Each sample frame it slew-limits every channel amplitude, scales each oscillator sample, sums with saturation and applies the envelope gain. Work is time-multiplexed, one channel per clock, so a single multiplier serves any NUM_OSC. It sits between the oscillator bank / ADSR and the voice summing bus.

Parameters:
NUM_OSC, 4, number of oscillator channels (>=1)
WIDTH, 16, sample/amplitude/envelope width
SLEW, 16'h0088, per-frame amplitude step (WIDTH bits); 0 = no smoothing (amplitude follows target directly)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
sample_tick  in  1  start-of-frame strobe
osc_in  in  NUM_OSC*WIDTH  packed signed oscillator samples, channel i at [i*WIDTH +: WIDTH]
amp_in  in  NUM_OSC*WIDTH  packed unsigned target amplitudes, same packing
env_in  in  WIDTH  unsigned envelope gain
out  out  WIDTH  signed mixed sample
out_valid  out  1  one-cycle pulse, out updated
busy  out  1  frame in progress

Behaviour:
- Clk is the only clock. Reset is synchronous and active-high.
- Reset (any state, including mid-frame): state IDLE; out=0; out_valid=0; busy=0; all smoothed amplitudes amp_s[i]=0; accumulator=0; partial frame discarded.
- States: IDLE, ACC, SCALE, DONE. busy = (state != IDLE).
- IDLE: if sample_tick=1 at edge T, latch osc_in, amp_in and env_in into a snapshot, clear the accumulator, set channel index k=0 and go to ACC. Inputs may change after edge T.
- ACC: one channel per edge, k=0..NUM_OSC-1 at edges T+1..T+NUM_OSC.
  - Slew update: if SLEW=0, amp_s=target.
  - Else if target > amp_s+SLEW, amp_s += SLEW.
  - Else if target+SLEW < amp_s, amp_s -= SLEW.
  - Else amp_s=target.
  - Compare in WIDTH+1 bits so there is no wrap.
  - Product p = signed(osc) * signed({1'b0,amp_s_new}), then arithmetic shift right by WIDTH (floor). 0xFFFF is approximately unity.
  - Accumulator width WIDTH+$clog2(NUM_OSC)+1, so it never overflows.
  - After k=NUM_OSC-1, go to SCALE.
- SCALE (edge T+NUM_OSC+1): saturate the accumulator to signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Result g = (sat * signed({1'b0,env})) >>> WIDTH. Go to DONE.
- DONE (edge T+NUM_OSC+2): out<=g, out_valid<=1 for exactly one cycle, go to IDLE. out holds its value until the next DONE.
- Latency: tick at edge T produces out_valid high after edge T+NUM_OSC+2. Minimum tick period is NUM_OSC+3 cycles.
- sample_tick while busy=1 (including the DONE cycle) is ignored. It is not queued.
- amp_s persists across frames; it changes only during ACC or on Reset.
- env_in=0 gives out=0. All amp=0 gives out=0 irrespective of osc.

Optional Feature:
Macro VOICE_MIX_CLIP_CNT_EN.
- Defined: adds output clip_count (16 bits, reset 0) and clip (1 bit, reset 0).
- clip is registered with out in DONE: 1 if SCALE saturated, else 0.
- clip_count increments on each saturated frame and sticks at 16'hFFFF.
- Not defined: ports and logic are absent; out behaviour is identical.

Test Plan:
1. Reset asserted for 2 cycles, mid-frame after a tick -> out=0, out_valid=0, busy=0 next cycle; a following tick gives a normal frame from amp_s=0.
2. NUM_OSC=4, SLEW=0. osc0=16'h2000, amp0=16'h8000, other channels amp=0, env=16'h8000, tick at T -> out_valid only after edge T+6, out=16'h0800, busy high exactly T+1..T+6.
3. SLEW=0, all osc=16'h4000, all amp=16'hFFFF, env=16'hFFFF -> sum 0xFFFC saturates, out=16'h7FFE, clip=1 and clip_count=1 (macro on).
4. SLEW=0, all osc=16'h8000, all amp=16'hFFFF, env=16'hFFFF -> negative saturation, out=16'h8000.
5. SLEW=16'h0088, amp0 target 16'h0110, osc0=16'h7FFF, env=16'hFFFF -> amp_s0 is 0x0088, 0x0110, 0x0110 over three frames; out increases then holds.
6. Tick repeated every cycle for 20 cycles -> frames start only from IDLE; out_valid pulses exactly once per NUM_OSC+3 cycles.
